// File: rtl/key_event_pkg.sv
// Shared constants for the button-handling blocks: FSM state codes and
// default timing values used by the debouncer and the key event generator.
package key_event_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  // 100 MHz system clock, 1 ms tick, 1 s long press, 200 ms repeat
  localparam int DEF_CLK_DIV   = 100000;
  localparam int DEF_DIV_W     = 17;
  localparam int DEF_LONG_MS   = 1000;
  localparam int DEF_REPEAT_MS = 200;
  localparam int DEF_CNT_W     = 11;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_PRESSED = ST_PRESSED,
    S_LONG    = ST_LONG,
    S_SPARE   = 2'd3
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_DIV-1 and flags the wrap cycle.
// A synchronous clear restarts the count so ms timing can be aligned
// to an external event.
module ms_tick_gen
  import key_event_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // tick is high in the last cycle of each CLK_DIV-long period
  assign tick = (div_cnt == DIV_LAST);

  // free-running prescaler with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Key event generator: turns the debounced button level into single-cycle
// press / release / short / long / auto-repeat events plus a holding level.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_lvl,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic holding
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  logic             s1;
  logic             s2;
  logic             s_prev;
  logic             rise;
  logic             fall;
  logic             tick;
  logic             tick_clr;
  logic [CNT_W-1:0] ms_cnt;
  state_t           state;

  // bring the asynchronous level into the clk domain and keep one cycle of history
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= btn_lvl;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rise = s2 & ~s_prev;
  assign fall = ~s2 & s_prev;

  // restarting the prescaler at the press makes every ms boundary
  // an exact multiple of CLK_DIV cycles after press_pulse
  assign tick_clr = (state == S_IDLE) && rise;

  ms_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // event FSM; release always beats a coincident long/repeat threshold
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      ms_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      holding       <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        S_IDLE: begin
          holding <= 1'b0;
          if (rise) begin
            press_pulse <= 1'b1;
            holding     <= 1'b1;
            ms_cnt      <= '0;
            state       <= S_PRESSED;
          end
        end
        S_PRESSED: begin
          holding <= 1'b1;
          if (fall) begin
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            holding       <= 1'b0;
            state         <= S_IDLE;
          end else if (tick) begin
            if (ms_cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              ms_cnt     <= '0;
              state      <= S_LONG;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        S_LONG: begin
          holding <= 1'b1;
          if (fall) begin
            release_pulse <= 1'b1;
            holding       <= 1'b0;
            state         <= S_IDLE;
          end else if (tick) begin
            if (ms_cnt == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              ms_cnt       <= '0;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        default: begin
          holding <= 1'b0;
          ms_cnt  <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Testbench for key_event_gen with CLK_DIV=4, LONG_MS=5, REPEAT_MS=2.
// Directed hold-length table, hand-written reset corner cases and random
// button activity, all compared against a hold-time reference model.
module tb_key_event_gen;

  localparam int T_CLK_DIV = 4;
  localparam int T_LONG_MS = 5;
  localparam int T_REP_MS  = 2;
  localparam int LONG_T    = T_LONG_MS * T_CLK_DIV;
  localparam int REP_T     = T_REP_MS * T_CLK_DIV;
  localparam int HIST      = 8192;

  logic clk = 1'b0;
  logic rst;
  logic btn_lvl;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, holding;

  key_event_gen #(
    .CLK_DIV   (T_CLK_DIV),
    .DIV_W     (3),
    .LONG_MS   (T_LONG_MS),
    .REPEAT_MS (T_REP_MS),
    .CNT_W     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_lvl       (btn_lvl),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .holding       (holding)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // sampled input history, one entry per clk edge
  bit hb [HIST];
  bit hr [HIST];
  int n;

  // reference model state: is the key down, and at which edge did it go down
  bit in_key;
  int p_edge;
  bit e_press, e_rel, e_short, e_long, e_rep, e_hold;

  typedef struct {
    int d;       // edges for which btn_lvl is sampled high
    int rel;     // release_pulse cycle relative to press_pulse
    int shrt;    // short_pulse expected with the release
    int longs;   // number of long_pulse
    int reps;    // number of repeat_pulse
  } vec_t;

  vec_t tbl [7];

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b want %b", nm, n, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0d want %0d", nm, n, act, exp);
    end
  endtask

  // level seen by the event logic after edge m: the sample from two edges
  // earlier, with any reset in between wiping it
  function automatic bit lvl(input int m);
    if (m < 1) return 1'b0;
    return (hr[m] && hr[m-1]) ? hb[m-1] : 1'b0;
  endfunction

  function automatic bit prv(input int m);
    if (m < 1) return 1'b0;
    return hr[m] ? lvl(m-1) : 1'b0;
  endfunction

  // expected outputs after edge n, from hold time since the press
  task automatic model_edge();
    bit now_l, was_l;
    int t;
    e_press = 1'b0; e_rel = 1'b0; e_short = 1'b0;
    e_long  = 1'b0; e_rep = 1'b0; e_hold  = 1'b0;
    if (!hr[n]) begin
      in_key = 1'b0;
    end else begin
      now_l = lvl(n-1);
      was_l = prv(n-1);
      if (!in_key) begin
        if (now_l && !was_l) begin
          e_press = 1'b1;
          e_hold  = 1'b1;
          in_key  = 1'b1;
          p_edge  = n;
        end
      end else if (!now_l && was_l) begin
        e_rel   = 1'b1;
        e_short = ((n - p_edge) <= LONG_T);
        in_key  = 1'b0;
      end else begin
        t      = n - p_edge;
        e_hold = 1'b1;
        if (t == LONG_T) e_long = 1'b1;
        else if (t > LONG_T && ((t - LONG_T) % REP_T) == 0) e_rep = 1'b1;
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn_lvl = b;
    rst     = r;
    @(posedge clk);
    #1;
    n++;
    if (n >= HIST - 1) begin
      $display("FAIL history overflow edge %0d", n);
      $fatal(1, "history overflow");
    end
    hb[n] = b;
    hr[n] = r;
    model_edge();
    chk_bit("press_pulse",   press_pulse,   e_press);
    chk_bit("release_pulse", release_pulse, e_rel);
    chk_bit("short_pulse",   short_pulse,   e_short);
    chk_bit("long_pulse",    long_pulse,    e_long);
    chk_bit("repeat_pulse",  repeat_pulse,  e_rep);
    chk_bit("holding",       holding,       e_hold);
  endtask

  task automatic run_hold(input int idx);
    int p_at, r_at, l_at, lcnt, rcnt, scnt, hcnt, s_at_rel;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    p_at = -1; r_at = -1; l_at = -1; s_at_rel = -1;
    lcnt = 0; rcnt = 0; scnt = 0; hcnt = 0;
    for (int c = 0; c < tbl[idx].d + 10; c++) begin
      step(c < tbl[idx].d, 1'b1);
      if (press_pulse && p_at < 0) p_at = c;
      if (release_pulse && r_at < 0) begin
        r_at     = c;
        s_at_rel = short_pulse ? 1 : 0;
      end
      if (long_pulse) begin
        lcnt++;
        l_at = c;
      end
      if (repeat_pulse) rcnt++;
      if (short_pulse) scnt++;
      if (holding) hcnt++;
    end
    chk_int("tbl press latency", p_at, 2);
    chk_int("tbl release offset", r_at - p_at, tbl[idx].rel);
    chk_int("tbl short at release", s_at_rel, tbl[idx].shrt);
    chk_int("tbl short count", scnt, tbl[idx].shrt);
    chk_int("tbl long count", lcnt, tbl[idx].longs);
    chk_int("tbl repeat count", rcnt, tbl[idx].reps);
    chk_int("tbl holding cycles", hcnt, tbl[idx].d);
    if (lcnt > 0) chk_int("tbl long offset", l_at - p_at, LONG_T);
  endtask

  initial begin
    int pulses, pk, rel, len;
    bit lv;
    rst = 1'b0; btn_lvl = 1'b0;
    checks = 0; errors = 0; n = 1;
    in_key = 1'b0; p_edge = 0;

    tbl[0] = '{d: 10, rel: 10, shrt: 1, longs: 0, reps: 0};  // short press
    tbl[1] = '{d: 40, rel: 40, shrt: 0, longs: 1, reps: 2};  // long hold, repeats at +28, +36
    tbl[2] = '{d: 20, rel: 20, shrt: 1, longs: 0, reps: 0};  // release races long threshold
    tbl[3] = '{d: 21, rel: 21, shrt: 0, longs: 1, reps: 0};  // just past long
    tbl[4] = '{d: 1,  rel: 1,  shrt: 1, longs: 0, reps: 0};  // single-sample blip
    tbl[5] = '{d: 28, rel: 28, shrt: 0, longs: 1, reps: 0};  // release races first repeat
    tbl[6] = '{d: 29, rel: 29, shrt: 0, longs: 1, reps: 1};  // just past first repeat

    // reset held low, then quiet
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk_bit("reset holding", holding, 1'b0);
    chk_bit("reset press", press_pulse, 1'b0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1);
      if (press_pulse || release_pulse || short_pulse || long_pulse || repeat_pulse || holding)
        pulses++;
    end
    chk_int("quiet after reset", pulses, 0);

    for (int i = 0; i < 7; i++) run_hold(i);

    // reset in the middle of a long hold
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    pk = -1;
    for (int c = 0; c < 6 && pk < 0; c++) begin
      step(1'b1, 1'b1);
      if (press_pulse) pk = c;
    end
    chk_int("midhold press latency", pk, 2);
    for (int i = 1; i < 25; i++) step(1'b1, 1'b1);
    chk_bit("midhold holding before reset", holding, 1'b1);
    step(1'b1, 1'b0);
    chk_bit("midhold holding in reset", holding, 1'b0);
    chk_bit("midhold release in reset", release_pulse, 1'b0);
    chk_bit("midhold short in reset", short_pulse, 1'b0);
    rel = 0; pk = -1;
    for (int j = 1; j <= 6; j++) begin
      step(1'b1, 1'b1);
      if (release_pulse) rel++;
      if (press_pulse && pk < 0) pk = j;
    end
    chk_int("midhold no release", rel, 0);
    chk_int("midhold re-press latency", pk, 3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    // button already down while reset is asserted
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    pk = -1;
    for (int j = 1; j <= 6; j++) begin
      step(1'b1, 1'b1);
      if (press_pulse && pk < 0) pk = j;
    end
    chk_int("powerup press latency", pk, 3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    // random button activity with occasional resets
    lv = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 14) == 0) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) step($urandom_range(0, 1) != 0, 1'b0);
      end else begin
        lv  = !lv;
        len = $urandom_range(1, 45);
        for (int j = 0; j < len; j++) step(lv, 1'b1);
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
